// File: rtl/buzzer_sfx.sv
// Buzzer sound-effect sequencer: short single-tone "fire" and longer two-tone
// "explosion" effects. The buzzer is active-low and idles high. Hit has
// priority over shoot.
module buzzer_sfx #(
  parameter int unsigned SHOOT_HALF = 50000,
  parameter int unsigned SHOOT_LEN  = 10000000,
  parameter int unsigned HIT_HALF_A = 100000,
  parameter int unsigned HIT_HALF_B = 200000,
  parameter int unsigned HIT_LEN    = 30000000
) (
  input  logic clk_100mhz,
  input  logic RSTN,
  input  logic shoot,
  input  logic hit,
  input  logic mute,
  output logic Buzzer,
  output logic busy
);

  typedef enum logic [1:0] {StIdle, StShoot, StHit} state_e;

  localparam logic [27:0] ShootHalfM1 = 28'(SHOOT_HALF - 1);
  localparam logic [27:0] ShootLenM1  = 28'(SHOOT_LEN - 1);
  localparam logic [27:0] HitHalfAM1  = 28'(HIT_HALF_A - 1);
  localparam logic [27:0] HitHalfBM1  = 28'(HIT_HALF_B - 1);
  localparam logic [27:0] HitLenM1    = 28'(HIT_LEN - 1);
  localparam logic [27:0] HitMid      = 28'(HIT_LEN / 2);

  state_e      state_q, state_d;
  logic [27:0] dur_q, dur_d;
  logic [27:0] ph_q, ph_d;
  logic        tone_q, tone_d;
  logic        buzzer_q, buzzer_d;
  logic        busy_q, busy_d;

  logic [27:0] half_m1;
  logic [27:0] len_m1;

  // Next-state: strobe priority, duration/phase counting and tone toggling.
  always_comb begin
    state_d  = state_q;
    dur_d    = dur_q;
    ph_d     = ph_q;
    tone_d   = tone_q;
    half_m1  = ShootHalfM1;
    len_m1   = ShootLenM1;

    if (state_q == StHit) begin
      len_m1  = HitLenM1;
      half_m1 = (dur_q < HitMid) ? HitHalfAM1 : HitHalfBM1;
    end

    if (hit) begin
      state_d = StHit;
      dur_d   = '0;
      ph_d    = '0;
      tone_d  = 1'b0;
    end else if (shoot && (state_q != StHit)) begin
      state_d = StShoot;
      dur_d   = '0;
      ph_d    = '0;
      tone_d  = 1'b0;
    end else if (state_q != StIdle) begin
      if (dur_q == len_m1) begin
        state_d = StIdle;
        dur_d   = '0;
        ph_d    = '0;
        tone_d  = 1'b0;
      end else begin
        dur_d = dur_q + 28'd1;
        if ((state_q == StHit) && (dur_d == HitMid)) begin
          // Tone B starts fresh in its sound-low phase.
          ph_d   = '0;
          tone_d = 1'b0;
        end else if (ph_q == half_m1) begin
          ph_d   = '0;
          tone_d = ~tone_q;
        end else begin
          ph_d = ph_q + 28'd1;
        end
      end
    end

    busy_d   = (state_d != StIdle);
    buzzer_d = (state_d == StIdle) ? 1'b1 : (mute | tone_d);
  end

  // State and registered outputs; reset forces the buzzer silent immediately.
  always_ff @(posedge clk_100mhz or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= StIdle;
      dur_q    <= '0;
      ph_q     <= '0;
      tone_q   <= 1'b0;
      buzzer_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dur_q    <= dur_d;
      ph_q     <= ph_d;
      tone_q   <= tone_d;
      buzzer_q <= buzzer_d;
      busy_q   <= busy_d;
    end
  end

  assign Buzzer = buzzer_q;
  assign busy   = busy_q;

endmodule
